arbitro_paralelo_serial: RTL and testbench

Four-requester scheduler that shares the byte-wide parallel-to-serial lane between independent byte sources. It buffers each requester in a small FIFO and runs a post-reset training window. It then grants the lane round-robin in bounded bursts and presents one byte per `clk_4f` cycle as `data_out`/`valid_out` to the serializer input (`data_in`/`valid_in`). Cycles with `valid_out=0` become COM idle symbols on the line.

---
 rtl/arbitro_paralelo_serial.sv | 192 +++++++++++++++++++
 tb/tb_arbitro_paralelo_serial.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_paralelo_serial.sv
// Four-requester round-robin scheduler feeding the byte-wide serializer lane.
// Per-requester FIFOs, post-reset training window, bounded bursts.
module arbitro_paralelo_serial #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_BURST  = 4,
    parameter int TRAIN_LEN  = 8
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic [7:0] data_in0,
    input  logic [7:0] data_in1,
    input  logic [7:0] data_in2,
    input  logic [7:0] data_in3,
    input  logic       valid_in0,
    input  logic       valid_in1,
    input  logic       valid_in2,
    input  logic       valid_in3,
    output logic [3:0] full,
    output logic [3:0] overflow,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic [3:0] grant
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        TRAIN,
        IDLE,
        SERVE
    } state_t;

    logic [7:0]    din [4];
    logic [3:0]    vin;

    logic [7:0]    mem_q [4][FIFO_DEPTH];
    logic [AW-1:0] wr_q  [4];
    logic [AW-1:0] rd_q  [4];
    logic [CW-1:0] cnt_q [4];
    logic [3:0]    ovf_q;

    logic [3:0]    push;
    logic [3:0]    pop;
    logic [3:0]    nonempty;

    state_t        state_q;
    logic [7:0]    train_q;
    logic [3:0]    burst_q;
    logic [1:0]    ptr_q;
    logic [1:0]    gidx_q;
    logic [3:0]    grant_q;
    logic [7:0]    data_q;
    logic          valid_q;

    logic [1:0]    cand;
    logic [1:0]    sel_idx;
    logic          sel_found;
    logic [7:0]    head;
    logic          last_pop;
    logic          burst_done;

    assign din[0] = data_in0;
    assign din[1] = data_in1;
    assign din[2] = data_in2;
    assign din[3] = data_in3;
    assign vin    = {valid_in3, valid_in2, valid_in1, valid_in0};

    assign overflow  = ovf_q;
    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign grant     = grant_q;

    // Per-FIFO status and push/pop strobes; a push while full is dropped.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            nonempty[i] = (cnt_q[i] != '0);
            full[i]     = (cnt_q[i] == CW'(FIFO_DEPTH));
            push[i]     = vin[i] && !full[i];
            pop[i]      = (state_q == SERVE) && (gidx_q == 2'(i));
        end
    end

    // First non-empty requester starting from the round-robin pointer.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr_q;
        cand      = ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!sel_found && nonempty[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Burst ends when the granted FIFO drains or the burst limit is hit.
    always_comb begin
        head       = mem_q[gidx_q][rd_q[gidx_q]];
        last_pop   = (cnt_q[gidx_q] == CW'(1)) && !push[gidx_q];
        burst_done = (burst_q == 4'(MAX_BURST - 1));
    end

    // FIFO storage; stale contents are harmless once pointers reset.
    always_ff @(posedge clk_4f) begin
        for (int i = 0; i < 4; i++) begin
            if (push[i]) begin
                mem_q[i][wr_q[i]] <= din[i];
            end
        end
    end

    // FIFO pointers, occupancy and sticky overflow flags.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                wr_q[i]  <= '0;
                rd_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push[i]) begin
                    wr_q[i] <= wr_q[i] + AW'(1);
                end
                if (pop[i]) begin
                    rd_q[i] <= rd_q[i] + AW'(1);
                end
                case ({push[i], pop[i]})
                    2'b10:   cnt_q[i] <= cnt_q[i] + CW'(1);
                    2'b01:   cnt_q[i] <= cnt_q[i] - CW'(1);
                    default: cnt_q[i] <= cnt_q[i];
                endcase
                if (vin[i] && full[i]) begin
                    ovf_q[i] <= 1'b1;
                end
            end
        end
    end

    // Scheduler FSM with registered lane outputs.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            state_q <= TRAIN;
            train_q <= '0;
            burst_q <= '0;
            ptr_q   <= '0;
            gidx_q  <= '0;
            grant_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                TRAIN: begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    grant_q <= '0;
                    train_q <= train_q + 8'd1;
                    if (train_q == 8'(TRAIN_LEN - 1)) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    if (sel_found) begin
                        gidx_q  <= sel_idx;
                        grant_q <= 4'b0001 << sel_idx;
                        burst_q <= '0;
                        state_q <= SERVE;
                    end
                end
                SERVE: begin
                    data_q  <= head;
                    valid_q <= 1'b1;
                    burst_q <= burst_q + 4'd1;
                    if (last_pop || burst_done) begin
                        state_q <= IDLE;
                        ptr_q   <= gidx_q + 2'd1;
                        grant_q <= '0;
                    end
                end
                default: begin
                    state_q <= TRAIN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_paralelo_serial.sv
// Scoreboard bench for arbitro_paralelo_serial.
// Directed stimulus; a negedge monitor checks the lane stream.
module tb_arbitro_paralelo_serial;

    logic       clk_4f = 1'b0;
    logic       reset  = 1'b0;
    logic [7:0] data_in0 = '0;
    logic [7:0] data_in1 = '0;
    logic [7:0] data_in2 = '0;
    logic [7:0] data_in3 = '0;
    logic       valid_in0 = 1'b0;
    logic       valid_in1 = 1'b0;
    logic       valid_in2 = 1'b0;
    logic       valid_in3 = 1'b0;
    logic [3:0] full;
    logic [3:0] overflow;
    logic [7:0] data_out;
    logic       valid_out;
    logic [3:0] grant;

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic       v;
        logic [3:0] g;
        logic [7:0] d;
    } exp_t;

    exp_t exp_q[$];
    logic [3:0] last_g = '0;
    bit started = 0;

    arbitro_paralelo_serial #(
        .FIFO_DEPTH(4),
        .MAX_BURST (4),
        .TRAIN_LEN (8)
    ) dut (
        .clk_4f   (clk_4f),
        .reset    (reset),
        .data_in0 (data_in0),
        .data_in1 (data_in1),
        .data_in2 (data_in2),
        .data_in3 (data_in3),
        .valid_in0(valid_in0),
        .valid_in1(valid_in1),
        .valid_in2(valid_in2),
        .valid_in3(valid_in3),
        .full     (full),
        .overflow (overflow),
        .data_out (data_out),
        .valid_out(valid_out),
        .grant    (grant)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drv(input int i, input logic v, input logic [7:0] d);
        case (i)
            0: begin valid_in0 = v; data_in0 = d; end
            1: begin valid_in1 = v; data_in1 = d; end
            2: begin valid_in2 = v; data_in2 = d; end
            default: begin valid_in3 = v; data_in3 = d; end
        endcase
    endtask

    task automatic clr_in();
        for (int i = 0; i < 4; i++) drv(i, 1'b0, 8'h00);
    endtask

    task automatic exp_b(input logic [3:0] g, input logic [7:0] d);
        exp_t e;
        e.v = 1'b1;
        e.g = g;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic exp_gap();
        exp_t e;
        e.v = 1'b0;
        e.g = 4'b0;
        e.d = 8'h00;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk_4f);
        reset = 1'b0;
        clr_in();
        @(negedge clk_4f);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk_4f);
        reset = 1'b1;
    endtask

    task automatic drain();
        for (int c = 0; c < 200; c++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk_4f);
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        @(negedge clk_4f);
    endtask

    task automatic wait_valid(input string name);
        bit got;
        got = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk_4f);
            if (valid_out) begin
                got = 1;
                break;
            end
        end
        chk(name, 32'(got), 32'd1);
    endtask

    // Monitor: every lane byte (and bubbles inside a stream) is popped and compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_4f);
            if (grant != 4'b0) last_g = grant;
            if (valid_out || (started && exp_q.size() > 0)) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected", 32'(valid_out), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    started = 1;
                    chk("sb_valid", 32'(valid_out), 32'(e.v));
                    chk("sb_data", 32'(data_out), 32'(e.d));
                    if (e.v) chk("sb_grant", 32'(last_g), 32'(e.g));
                    if (exp_q.size() == 0) started = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rem;

        // Reset release with no traffic: lane stays quiet.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_4f);
            chk("quiet", 32'({valid_out, data_out, grant}), 32'd0);
        end

        // Latency from IDLE: three bytes to requester 1.
        exp_b(4'b0010, 8'h11);
        exp_b(4'b0010, 8'h22);
        exp_b(4'b0010, 8'h33);
        drv(1, 1'b1, 8'h11);
        @(negedge clk_4f);
        chk("lat_e0_grant", 32'(grant), 32'd0);
        drv(1, 1'b1, 8'h22);
        @(negedge clk_4f);
        chk("lat_e1_grant", 32'(grant), 32'b0010);
        chk("lat_e1_valid", 32'(valid_out), 32'd0);
        drv(1, 1'b1, 8'h33);
        @(negedge clk_4f);
        chk("lat_e2", 32'({valid_out, data_out}), 32'h111);
        drv(1, 1'b0, 8'h00);
        @(negedge clk_4f);
        chk("lat_e3", 32'({valid_out, data_out}), 32'h122);
        @(negedge clk_4f);
        chk("lat_e4", 32'({valid_out, data_out, grant}), 32'h1330);
        @(negedge clk_4f);
        chk("lat_e5", 32'({valid_out, data_out, grant}), 32'd0);
        drain();

        // Preload all four FIFOs during training.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) exp_b(4'(1 << i), 8'(i * 16 + k));
            if (i < 3) exp_gap();
        end
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) drv(i, 1'b1, 8'(i * 16 + k));
            @(negedge clk_4f);
        end
        clr_in();
        repeat (4) @(negedge clk_4f);
        chk("train_end_grant", 32'(grant), 32'd0);
        @(negedge clk_4f);
        chk("first_grant", 32'(grant), 32'b0001);
        drain();

        // Requester 2 refilled, requester 3 holds a single byte.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drv(2, 1'b1, 8'h50 + 8'(k));
            if (k == 0) drv(3, 1'b1, 8'hAA);
            else drv(3, 1'b0, 8'h00);
            @(negedge clk_4f);
        end
        clr_in();
        for (int k = 0; k < 4; k++) exp_b(4'b0100, 8'h50 + 8'(k));
        exp_gap();
        exp_b(4'b1000, 8'hAA);
        exp_gap();
        for (int k = 0; k < 4; k++) exp_b(4'b0100, 8'h54 + 8'(k));
        rem = 0;
        for (int c = 0; c < 60 && rem < 4; c++) begin
            @(negedge clk_4f);
            if (!full[2]) begin
                drv(2, 1'b1, 8'h54 + 8'(rem));
                rem++;
            end else begin
                drv(2, 1'b0, 8'h00);
            end
        end
        @(negedge clk_4f);
        drv(2, 1'b0, 8'h00);
        chk("refill_done", 32'(rem), 32'd4);
        drain();
        chk("refill_ovf", 32'(overflow), 32'd0);

        // Overfill requester 0 during training.
        do_reset();
        for (int k = 0; k < 4; k++) exp_b(4'b0001, 8'h60 + 8'(k));
        for (int k = 0; k < 5; k++) begin
            drv(0, 1'b1, 8'h60 + 8'(k));
            @(negedge clk_4f);
            if (k == 3) begin
                chk("full_4th", 32'(full[0]), 32'd1);
                chk("ovf_4th", 32'(overflow[0]), 32'd0);
            end
            if (k == 4) begin
                chk("full_5th", 32'(full[0]), 32'd1);
                chk("ovf_5th", 32'(overflow[0]), 32'd1);
            end
        end
        drv(0, 1'b0, 8'h00);
        wait_valid("ovf_wait_pop");
        chk("full_after_pop", 32'(full[0]), 32'd0);
        chk("ovf_after_pop", 32'(overflow[0]), 32'd1);
        drain();
        chk("ovf_sticky", 32'(overflow), 32'b0001);

        // Reset mid-burst flushes buffered bytes.
        do_reset();
        exp_b(4'b0010, 8'h70);
        exp_b(4'b0010, 8'h71);
        for (int k = 0; k < 4; k++) begin
            drv(1, 1'b1, 8'h70 + 8'(k));
            @(negedge clk_4f);
        end
        drv(1, 1'b0, 8'h00);
        wait_valid("abort_wait");
        @(negedge clk_4f);
        #1 reset = 1'b0;
        #1;
        chk("abort_out", 32'({valid_out, data_out, grant}), 32'd0);
        chk("abort_flags", 32'({full, overflow}), 32'd0);
        @(negedge clk_4f);
        @(negedge clk_4f);
        reset = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk_4f);
            chk("post_abort", 32'({valid_out, data_out, grant}), 32'd0);
        end

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
